branch_checkpoint_manager: RTL and testbench

- Allocates and tracks branch IDs (BRIDs) that index the register allocator's rename checkpoints.
- Sits between decode/rename and the register allocator. It hands out BRIDs in program order and frees them as branches resolve.
- On a misprediction it emits the mispredicted BRID and squashes all younger BRIDs.
- Internally it is a circular queue of NumCheckpoints entries with out-of-order resolution and in-order retirement.

---
 rtl/branch_checkpoint_manager.sv | 152 +++++++++++++++
 tb/tb_branch_checkpoint_manager.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_checkpoint_manager.sv
`default_nettype none
// ============================================================================
// Module   : branch_checkpoint_manager
// Purpose  : Hands out branch IDs (BRIDs) in program order for the register
//            allocator's rename checkpoints. Branches resolve out of order and
//            retire in order. A misprediction squashes the mispredicted BRID
//            and every younger one, then reports it as a registered pulse.
// Revision : 1.0 - initial release
// ============================================================================
module branch_checkpoint_manager #(
   parameter int BridWidth = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 alloc_req_i,
   output logic                 alloc_gnt_o,
   output logic [BridWidth-1:0] alloc_brid_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [BridWidth:0]   inflight_count_o,
   input  logic                 resolve_valid_i,
   input  logic [BridWidth-1:0] resolve_brid_i,
   input  logic                 resolve_mispredict_i,
   output logic                 missprediction_o,
   output logic [BridWidth-1:0] missprediction_brid_o
);

   localparam int NumCheckpoints = 1 << BridWidth;

   // Architectural state
   logic [BridWidth-1:0]      head_q;
   logic [BridWidth-1:0]      tail_q;
   logic [BridWidth:0]        count_q;
   logic [NumCheckpoints-1:0] valid_q;
   logic [NumCheckpoints-1:0] resolved_q;
   logic                      mp_q;
   logic [BridWidth-1:0]      mp_brid_q;

   // Next-state values
   logic [BridWidth-1:0]      head_d;
   logic [BridWidth-1:0]      tail_d;
   logic [BridWidth:0]        count_d;
   logic [NumCheckpoints-1:0] valid_d;
   logic [NumCheckpoints-1:0] resolved_d;

   // Decoded per-cycle events
   logic                      resolve_hit;
   logic                      mp_accept;
   logic                      ok_accept;
   logic                      retire;
   logic                      grant;
   logic [BridWidth-1:0]      squash_age;
   logic [NumCheckpoints-1:0] squash_mask;

   // A resolve only counts when it names a live entry; a flush drops it.
   assign resolve_hit = resolve_valid_i & valid_q[resolve_brid_i];
   assign mp_accept   = resolve_hit &  resolve_mispredict_i & ~flush_i;
   assign ok_accept   = resolve_hit & ~resolve_mispredict_i & ~flush_i;

   // Mispredicting the head itself squashes it, so it cannot also retire.
   assign retire = valid_q[head_q] & resolved_q[head_q]
                 & ~(mp_accept & (resolve_brid_i == head_q));

   // Grant is gated by any mispredict indication, accepted or not.
   assign grant = alloc_req_i & ~full_o & ~flush_i
                & ~(resolve_valid_i & resolve_mispredict_i);

   // Age of the mispredicted entry relative to the oldest one.
   assign squash_age = resolve_brid_i - head_q;

   assign full_o           = (count_q == (BridWidth+1)'(NumCheckpoints));
   assign empty_o          = (count_q == '0);
   assign inflight_count_o = count_q;
   assign alloc_brid_o     = tail_q;
   assign alloc_gnt_o      = grant;
   assign missprediction_o      = mp_q;
   assign missprediction_brid_o = mp_brid_q;

   // Mark every slot at least as young as the mispredicted branch; slots that
   // are not in flight are already clear, so masking them is harmless.
   always_comb begin
      logic [BridWidth-1:0] age;
      squash_mask = '0;
      for (int i = 0; i < NumCheckpoints; i++) begin
         age = BridWidth'(i) - head_q;
         squash_mask[i] = (age >= squash_age);
      end
   end

   // Compute per-entry bits, pointers and occupancy for the next cycle.
   always_comb begin
      valid_d    = valid_q;
      resolved_d = resolved_q;
      head_d     = head_q + BridWidth'(retire);
      tail_d     = tail_q;
      count_d    = count_q;

      if (ok_accept) begin
         resolved_d[resolve_brid_i] = 1'b1;
      end
      if (retire) begin
         valid_d[head_q]    = 1'b0;
         resolved_d[head_q] = 1'b0;
      end

      if (mp_accept) begin
         valid_d    = valid_d & ~squash_mask;
         resolved_d = resolved_d & ~squash_mask;
         tail_d     = resolve_brid_i;
         count_d    = {1'b0, squash_age} - (BridWidth+1)'(retire);
      end else begin
         if (grant) begin
            valid_d[tail_q]    = 1'b1;
            resolved_d[tail_q] = 1'b0;
            tail_d             = tail_q + BridWidth'(1);
         end
         count_d = count_q + (BridWidth+1)'(grant) - (BridWidth+1)'(retire);
      end
   end

   // State update: reset beats flush, flush beats normal operation.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         valid_q    <= '0;
         resolved_q <= '0;
         mp_q       <= 1'b0;
         mp_brid_q  <= '0;
      end else if (flush_i) begin
         head_q     <= tail_q;
         count_q    <= '0;
         valid_q    <= '0;
         resolved_q <= '0;
         mp_q       <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         resolved_q <= resolved_d;
         mp_q       <= mp_accept;
         if (mp_accept) begin
            mp_brid_q <= resolve_brid_i;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_checkpoint_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_checkpoint_manager
// Purpose  : Directed scenarios plus randomized traffic for the branch
//            checkpoint manager, checked against an in-order queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_checkpoint_manager;

   localparam int BW = 2;
   localparam int N  = 1 << BW;

   logic          clk = 1'b0;
   logic          rst, flush, req, rv, rmp;
   logic [BW-1:0] rbrid;
   logic          gnt, full, empty, mp;
   logic [BW-1:0] abrid, mpbrid;
   logic [BW:0]   cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: oldest-first list of in-flight branches (resolved flag
   // per branch); BRID of list position i is (m_head + i) mod N.
   int m_head  = 0;
   bit m_res[$];
   bit m_pulse = 0;
   int m_pbrid = 0;

   branch_checkpoint_manager #(.BridWidth(BW)) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .flush_i               (flush),
      .alloc_req_i           (req),
      .alloc_gnt_o           (gnt),
      .alloc_brid_o          (abrid),
      .full_o                (full),
      .empty_o               (empty),
      .inflight_count_o      (cnt),
      .resolve_valid_i       (rv),
      .resolve_brid_i        (rbrid),
      .resolve_mispredict_i  (rmp),
      .missprediction_o      (mp),
      .missprediction_brid_o (mpbrid)
   );

   always #5 clk = ~clk;

   function automatic int m_find(int b);
      for (int i = 0; i < m_res.size(); i++)
         if ((m_head + i) % N == b) return i;
      return -1;
   endfunction

   function automatic bit m_gnt();
      return req && (m_res.size() < N) && !flush && !(rv && rmp);
   endfunction

   function automatic int m_tail();
      return (m_head + m_res.size()) % N;
   endfunction

   task automatic drive(input bit r, input bit f, input bit a, input bit v,
                        input bit m, input int b);
      rst = r; flush = f; req = a; rv = v; rmp = m; rbrid = b[BW-1:0];
      #1;
   endtask

   // Advance one clock and apply the same inputs to the model.
   task automatic tick();
      bit g;
      bit ret;
      int k;
      g = m_gnt();
      @(posedge clk);
      if (rst) begin
         m_head = 0; m_res.delete(); m_pulse = 0; m_pbrid = 0;
      end else if (flush) begin
         m_head = (m_head + m_res.size()) % N;
         m_res.delete();
         m_pulse = 0;
      end else begin
         k   = rv ? m_find(int'(rbrid)) : -1;
         ret = (m_res.size() > 0) && m_res[0];
         if (k >= 0 && rmp) begin
            m_pulse = 1; m_pbrid = int'(rbrid);
            while (m_res.size() > k) void'(m_res.pop_back());
            if (k > 0 && ret) begin
               void'(m_res.pop_front());
               m_head = (m_head + 1) % N;
            end
         end else begin
            m_pulse = 0;
            if (k >= 0) m_res[k] = 1'b1;
            if (ret) begin
               void'(m_res.pop_front());
               m_head = (m_head + 1) % N;
            end
            if (g) m_res.push_back(1'b0);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         tick();
      end
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (cnt !== 3'd0)  begin errors++; $display("FAIL reset_count got %0d want 0", cnt); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
      checks++; if (full !== 1'b0)  begin errors++; $display("FAIL reset_full got %0b want 0", full); end
      checks++; if (mp !== 1'b0)    begin errors++; $display("FAIL reset_mp got %0b want 0", mp); end
      checks++; if (mpbrid !== 2'd0) begin errors++; $display("FAIL reset_mpbrid got %0d want 0", mpbrid); end
      checks++; if (abrid !== 2'd0) begin errors++; $display("FAIL reset_abrid got %0d want 0", abrid); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < N; i++) begin
         drive(0, 0, 1, 0, 0, 0);
         checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL fill_gnt%0d got %0b want 1", i, gnt); end
         checks++; if (int'(abrid) != i) begin errors++; $display("FAIL fill_brid%0d got %0d want %0d", i, abrid, i); end
         tick();
      end
      drive(0, 0, 1, 0, 0, 0);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b want 1", full); end
      checks++; if (cnt !== 3'd4)  begin errors++; $display("FAIL fill_count got %0d want 4", cnt); end
      checks++; if (gnt !== 1'b0)  begin errors++; $display("FAIL fill_5th_gnt got %0b want 0", gnt); end
      tick();
   endtask

   task automatic test_resolve_retire();
      drive(0, 0, 0, 1, 0, 2); tick();
      drive(0, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL retire_latency got %0d want 4", cnt); end
      tick();
      checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL retire_first got %0d want 3", cnt); end
      tick();
      checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL retire_blocked got %0d want 3", cnt); end
      drive(0, 0, 0, 1, 0, 1); tick();
      idle(2);
      checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL retire_chain got %0d want 1", cnt); end
      checks++; if (abrid !== 2'd0) begin errors++; $display("FAIL retire_tail got %0d want 0", abrid); end
   endtask

   task automatic test_mispredict();
      test_reset();
      for (int i = 0; i < N; i++) begin drive(0, 0, 1, 0, 0, 0); tick(); end
      drive(0, 0, 1, 1, 1, 1);
      checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL mp_gnt got %0b want 0", gnt); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (mp !== 1'b1)     begin errors++; $display("FAIL mp_pulse got %0b want 1", mp); end
      checks++; if (mpbrid !== 2'd1) begin errors++; $display("FAIL mp_brid got %0d want 1", mpbrid); end
      checks++; if (cnt !== 3'd1)    begin errors++; $display("FAIL mp_count got %0d want 1", cnt); end
      checks++; if (abrid !== 2'd1)  begin errors++; $display("FAIL mp_tail got %0d want 1", abrid); end
      tick();
      drive(0, 0, 1, 0, 0, 0);
      checks++; if (mp !== 1'b0)  begin errors++; $display("FAIL mp_one_cycle got %0b want 0", mp); end
      checks++; if (gnt !== 1'b1 || abrid !== 2'd1) begin errors++; $display("FAIL mp_regrant got gnt=%0b brid=%0d want 1/1", gnt, abrid); end
      tick();
   endtask

   task automatic test_wrap();
      test_reset();
      for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0, 0, 0); tick(); end
      for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 1, 0, i); tick(); end
      idle(1);
      for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 0, 0, 0); tick(); end
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (cnt !== 3'd2 || abrid !== 2'd1) begin errors++; $display("FAIL wrap_setup got cnt=%0d tail=%0d want 2/1", cnt, abrid); end
      drive(0, 0, 0, 1, 1, 3); tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (mp !== 1'b1 || mpbrid !== 2'd3) begin errors++; $display("FAIL wrap_pulse got %0b/%0d want 1/3", mp, mpbrid); end
      checks++; if (cnt !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got cnt=%0d empty=%0b want 0/1", cnt, empty); end
      checks++; if (abrid !== 2'd3) begin errors++; $display("FAIL wrap_tail got %0d want 3", abrid); end
      idle(1);
   endtask

   task automatic test_concurrent();
      test_reset();
      for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0, 0, 0); tick(); end
      drive(0, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 1, 0, 0, 0);
      checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL conc_gnt got %0b want 1", gnt); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL conc_grant_retire got %0d want 3", cnt); end
      drive(0, 0, 1, 1, 1, 2);
      checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL conc_mp_gate got %0b want 0", gnt); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (mp !== 1'b1 || mpbrid !== 2'd2 || cnt !== 3'd1) begin errors++; $display("FAIL conc_mp got %0b/%0d/%0d want 1/2/1", mp, mpbrid, cnt); end
      drive(0, 0, 0, 1, 1, 3); tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (mp !== 1'b0 || cnt !== 3'd1 || abrid !== 2'd2) begin errors++; $display("FAIL conc_invalid got %0b/%0d/%0d want 0/1/2", mp, cnt, abrid); end
   endtask

   task automatic test_flush();
      test_reset();
      for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0, 0, 0); tick(); end
      drive(0, 1, 1, 1, 1, 1);
      checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL flush_gnt got %0b want 0", gnt); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (cnt !== 3'd0 || empty !== 1'b1 || mp !== 1'b0) begin errors++; $display("FAIL flush_state got cnt=%0d empty=%0b mp=%0b want 0/1/0", cnt, empty, mp); end
      checks++; if (abrid !== 2'd3) begin errors++; $display("FAIL flush_tail got %0d want 3", abrid); end
      for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 0, 0, 0); tick(); end
      drive(0, 0, 0, 1, 1, 0); tick();
      drive(0, 1, 0, 0, 0, 0);
      checks++; if (mp !== 1'b1 || mpbrid !== 2'd0) begin errors++; $display("FAIL flush_prior_pulse got %0b/%0d want 1/0", mp, mpbrid); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (mp !== 1'b0 || cnt !== 3'd0) begin errors++; $display("FAIL flush_after got %0b/%0d want 0/0", mp, cnt); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 0, 0, 0); tick(); end
      drive(0, 0, 0, 1, 1, 0); tick();
      drive(1, 0, 1, 1, 0, 1); tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (cnt !== 3'd0 || mp !== 1'b0 || mpbrid !== 2'd0 || abrid !== 2'd0 || full !== 1'b0 || empty !== 1'b1)
         begin errors++; $display("FAIL reset_mid got cnt=%0d mp=%0b mpbrid=%0d tail=%0d", cnt, mp, mpbrid, abrid); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(99) == 0), ($urandom_range(29) == 0), $urandom_range(1),
               $urandom_range(1), ($urandom_range(3) == 0), int'($urandom_range(N-1)));
         checks++; if (gnt !== m_gnt()) begin errors++; $display("FAIL rnd_gnt cyc %0d got %0b want %0b", n, gnt, m_gnt()); end
         checks++; if (int'(abrid) != m_tail()) begin errors++; $display("FAIL rnd_tail cyc %0d got %0d want %0d", n, abrid, m_tail()); end
         checks++; if (int'(cnt) != m_res.size()) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", n, cnt, m_res.size()); end
         checks++; if (full !== (m_res.size() == N) || empty !== (m_res.size() == 0))
            begin errors++; $display("FAIL rnd_flags cyc %0d got full=%0b empty=%0b size %0d", n, full, empty, m_res.size()); end
         checks++; if (mp !== m_pulse) begin errors++; $display("FAIL rnd_pulse cyc %0d got %0b want %0b", n, mp, m_pulse); end
         if (m_pulse) begin
            checks++; if (int'(mpbrid) != m_pbrid) begin errors++; $display("FAIL rnd_mpbrid cyc %0d got %0d want %0d", n, mpbrid, m_pbrid); end
         end
         tick();
      end
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      test_reset();
      test_fill();
      test_resolve_retire();
      test_mispredict();
      test_wrap();
      test_concurrent();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
